// File: rtl/ddr_lfsr_tx.sv
// ddr_lfsr_tx: transmit-side DDR throughput pattern generator.
// Emits the 5-bit XNOR LFSR stream (two bits per clock in DDR, one in SDR)
// in fixed-length or continuous bursts under a small IDLE/RUN/DONE FSM.
module ddr_lfsr_tx #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             sdr_mode,
    input  logic [LEN_W-1:0] burst_len,
    output logic             ddr_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       lfsr_q, lfsr_d;
    logic             first_q, first_d;
    logic             second_q, second_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sdr_q, sdr_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [4:0]       step1, step2;
    logic             burst_end;

    // One LFSR advance; the all-ones lockup state is steered back to zero.
    function automatic logic [4:0] lfsr_step(input logic [4:0] s);
        logic [4:0] r;
        if (s == 5'b11111) begin
            r = 5'b00000;
        end else begin
            r = {s[3:0], ~(s[4] ^ s[2])};
        end
        return r;
    endfunction

    // Add the bits emitted this clock, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Next-state logic: FSM, LFSR advance, pair counter and output bit pair.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        first_d   = first_q;
        second_d  = second_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sdr_d     = sdr_q;
        bcnt_d    = bcnt_q;
        step1     = lfsr_step(lfsr_q);
        step2     = lfsr_step(step1);
        burst_end = stop || ((len_q != '0) && (cnt_q == len_q));
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        len_d   = burst_len;
                        sdr_d   = sdr_mode;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                        lfsr_d  = 5'b00000;
                    end
                end
                ST_RUN: begin
                    if (burst_end) begin
                        // Abort or final count: no data this clock, line parked low.
                        state_d  = ST_DONE;
                        first_d  = 1'b0;
                        second_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (sdr_q) begin
                            first_d  = step1[0];
                            second_d = step1[0];
                            lfsr_d   = step1;
                            bcnt_d   = sat_add(bcnt_q, 2'd1);
                        end else begin
                            first_d  = step1[0];
                            second_d = step2[0];
                            lfsr_d   = step2;
                            bcnt_d   = sat_add(bcnt_q, 2'd2);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous clear; ena gating is folded into _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= 5'b00000;
            first_q  <= 1'b0;
            second_q <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            sdr_q    <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            first_q  <= first_d;
            second_q <= second_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sdr_q    <= sdr_d;
            bcnt_q   <= bcnt_d;
        end
    end

    // Output mux: first bit during the high phase, second during the low phase.
    always_comb begin
        ddr_out = clk ? first_q : second_q;
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign bit_count = bcnt_q;

endmodule

// File: tb/tb_ddr_lfsr_tx.sv
// Testbench for ddr_lfsr_tx: directed and randomized bursts checked against
// a bit-stream recurrence model of the LFSR pattern.
module tb_ddr_lfsr_tx;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, stop, sdr_mode;
    logic [7:0]  burst_len;
    logic        ddr_out, busy, done;
    logic [15:0] bit_count;
    logic        ddr_out_s, busy_s, done_s;
    logic [5:0]  bit_count_s;

    int n_vec = 0;
    int n_err = 0;
    logic ref_bits [0:30];
    int   k;

    ddr_lfsr_tx #(.CNT_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .sdr_mode(sdr_mode), .burst_len(burst_len), .ddr_out(ddr_out),
        .busy(busy), .done(done), .bit_count(bit_count)
    );

    // Narrow-counter copy, driven identically, to exercise saturation.
    ddr_lfsr_tx #(.CNT_W(6), .LEN_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .sdr_mode(sdr_mode), .burst_len(burst_len), .ddr_out(ddr_out_s),
        .busy(busy_s), .done(done_s), .bit_count(bit_count_s)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bcnt(input int nbits);
        chk("bcnt", {16'd0, bit_count}, nbits);
        chk("bcnt_sat", {26'd0, bit_count_s}, (nbits > 63) ? 63 : nbits);
    endtask

    // One burst from IDLE; called just after a negedge, returns just after a negedge.
    task automatic do_burst(input logic sdr, input int len, input int nstop,
                            input int freeze_at, input logic stop_at_end);
        int   nb;
        int   nclk;
        logic prev_first;
        nb = 0;
        prev_first = 1'b0;
        nclk = (len != 0) ? len : nstop;
        sdr_mode  = sdr;
        burst_len = 8'(len);
        start     = 1'b1;
        stop      = 1'b0;
        @(posedge clk); #1;
        chk("busy_rise", busy, 1);
        chk("done_idle", done, 0);
        chk_bcnt(0);
        @(negedge clk);
        start     = 1'b0;
        sdr_mode  = ~sdr;
        burst_len = 8'($urandom);
        for (int c = 0; c < nclk; c++) begin
            if (c == freeze_at) begin
                ena = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("frz_out", ddr_out, prev_first);
                    chk("frz_busy", busy, 1);
                    chk_bcnt(nb);
                    @(negedge clk);
                end
                ena = 1'b1;
            end
            @(posedge clk); #1;
            chk("hi", ddr_out, ref_bits[nb % 31]);
            chk("busy", busy, 1);
            chk("done_run", done, 0);
            prev_first = ref_bits[nb % 31];
            @(negedge clk); #1;
            chk("lo", ddr_out, sdr ? ref_bits[nb % 31] : ref_bits[(nb + 1) % 31]);
            nb += sdr ? 1 : 2;
            chk_bcnt(nb);
        end
        if (len == 0 || stop_at_end) stop = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("out_zero_hi", ddr_out, 0);
        chk_bcnt(nb);
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk("out_zero_lo", ddr_out, 0);
        @(posedge clk); #1;
        chk("done_once", done, 0);
        chk("busy_idle", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [35:0] h;
        logic        rs, re;
        int          rl, rn, rf;

        // Reference stream: b[n] = ~(b[n-5] ^ b[n-3]) starting from five zeros.
        h = '0;
        for (int j = 5; j < 36; j++) h[j] = ~(h[j-5] ^ h[j-3]);
        for (int j = 0; j < 31; j++) ref_bits[j] = h[j+5];

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
        sdr_mode = 1'b0; burst_len = 8'd0;
        #2;
        chk("rst_out", ddr_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_bcnt(0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // DDR, length 4; then SDR, length 3; then continuous DDR with stop.
        do_burst(1'b0, 4, 0, -1, 1'b0);
        do_burst(1'b1, 3, 0, -1, 1'b0);
        do_burst(1'b0, 0, 40, -1, 1'b0);

        // Reset in the middle of a continuous burst.
        sdr_mode = 1'b0; burst_len = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_out", ddr_out, 0);
        chk_bcnt(0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_done", done, 0);
            chk("rst_hold_out", ddr_out, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        do_burst(1'b0, 2, 0, -1, 1'b0);

        // Lockup recovery: deposit all-ones into the LFSR during an SDR stream.
        sdr_mode = 1'b1; burst_len = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        dut.lfsr_q = 5'b11111;
        @(posedge clk); #1;
        chk("lock_state", dut.lfsr_q, 0);
        chk("lock_bit", ddr_out, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("lock_hi", ddr_out, ref_bits[i]);
            @(negedge clk); #1;
            chk("lock_lo", ddr_out, ref_bits[i]);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        chk("lock_done", done, 1);
        chk("lock_bcnt", {16'd0, bit_count}, 6);
        @(negedge clk);
        stop = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // start held high: back-to-back bursts of length 2.
        sdr_mode = 1'b0; burst_len = 8'd2; start = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1;
            chk("rep_busy", busy, 1);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                chk("rep_hi", ddr_out, ref_bits[2*c]);
                @(negedge clk); #1;
                chk("rep_lo", ddr_out, ref_bits[2*c+1]);
            end
            @(posedge clk); #1;
            chk("rep_done", done, 1);
            chk("rep_busy_dn", busy, 0);
            @(posedge clk); #1;
            chk("rep_idle_done", done, 0);
            chk("rep_idle_busy", busy, 0);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("rep_stays_idle", busy, 0);
        @(negedge clk);

        // Enable freeze mid-burst; stop coincident with the final count.
        do_burst(1'b0, 5, 0, 2, 1'b0);
        do_burst(1'b1, 4, 0, 0, 1'b0);
        do_burst(1'b1, 3, 0, -1, 1'b1);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            rs = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            rn = $urandom_range(1, 36);
            rf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            re = 1'($urandom_range(0, 1));
            do_burst(rs, rl, rn, rf, re);
        end

        k = n_err;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, k);
        $finish;
    end

endmodule
